// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, FSM state type and timing helper for sa_tile_feeder
package sa_pkg;

  localparam int N_DEFAULT          = 4;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int ACC_WIDTH_DEFAULT  = 2 * DATA_WIDTH_DEFAULT + $clog2(N_DEFAULT);

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } sa_state_e;

  // Cycle, counted from the first STREAM cycle, at which every accumulator is final:
  // the last operand pair reaches PE[N-1][N-1] at 3N-3, plus the PE pipeline.
  function automatic int done_cycle(input int n, input int pe_lat);
    return 3 * n - 3 + pe_lat;
  endfunction

endpackage

// File: rtl/sa_tile_bank.sv
// rtl/sa_tile_bank.sv - N x N A/B operand storage, written by beat, read per skewed index
module sa_tile_bank #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [IW-1:0]           wr_k_i,
  input  logic [N*DATA_WIDTH-1:0] wr_a_col_i,
  input  logic [N*DATA_WIDTH-1:0] wr_b_row_i,
  input  logic [N*IW-1:0]         rd_idx_i,
  output logic [N*DATA_WIDTH-1:0] rd_a_o,
  output logic [N*DATA_WIDTH-1:0] rd_b_o
);

  logic [DATA_WIDTH-1:0] a_q [N][N];
  logic [DATA_WIDTH-1:0] b_q [N][N];

  // Beat k carries column k of A and row k of B.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < N; i++) begin
        a_q[i][wr_k_i] <= wr_a_col_i[i*DATA_WIDTH +: DATA_WIDTH];
        b_q[wr_k_i][i] <= wr_b_row_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lane g reads A[g][idx_g] for the west edge and B[idx_g][g] for the north edge.
  for (genvar g = 0; g < N; g++) begin : g_rd
    assign rd_a_o[g*DATA_WIDTH +: DATA_WIDTH] = a_q[g][rd_idx_i[g*IW +: IW]];
    assign rd_b_o[g*DATA_WIDTH +: DATA_WIDTH] = b_q[rd_idx_i[g*IW +: IW]][g];
  end

endmodule

// File: rtl/sa_tile_feeder.sv
// rtl/sa_tile_feeder.sv - tile buffer and skewed edge driver for an N x N systolic array
// Optional: define SA_FEEDER_DOUBLE_BUF_EN for ping-pong banks with overlapped loading.
module sa_tile_feeder
  import sa_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int PE_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a_col,
  input  logic [N*DATA_WIDTH-1:0] in_b_row,
  output logic                    arr_clr,
  output logic [N*DATA_WIDTH-1:0] arr_a,
  output logic [N*DATA_WIDTH-1:0] arr_b,
  output logic                    res_valid,
  output logic                    busy
);

  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int CW     = $clog2(3 * N + PE_LAT);
  localparam int DONE_T = done_cycle(N, PE_LAT);
  localparam int SW     = N * DATA_WIDTH;

  sa_state_e       state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [CW-1:0]   t_q, t_d;
  logic [SW-1:0]   arr_a_q, arr_a_d, arr_b_q, arr_b_d;
  logic [SW-1:0]   rd_a, rd_b;
  logic [N*IW-1:0] rd_idx;
  logic            accept, last_beat, full_now;

  assign accept    = in_valid && in_ready;
  assign last_beat = accept && (k_q == IW'(N - 1));

`ifdef SA_FEEDER_DOUBLE_BUF_EN
  logic            fill_full_q, fill_full_d, rd_sel_q, rd_sel_d, start_tile;
  logic [SW-1:0]   rd_a_bank [2];
  logic [SW-1:0]   rd_b_bank [2];

  // The fill bank is always the one not being streamed; entering CLEAR hands it over.
  assign in_ready   = !fill_full_q;
  assign full_now   = fill_full_q || last_beat;
  assign start_tile = (state_d == CLEAR) && (state_q != CLEAR);

  // Track fill-bank occupancy and which bank feeds the array.
  always_comb begin
    fill_full_d = fill_full_q;
    rd_sel_d    = rd_sel_q;
    if (last_beat) fill_full_d = 1'b1;
    if (start_tile) begin
      fill_full_d = 1'b0;
      rd_sel_d    = ~rd_sel_q;
    end
  end

  // Bank bookkeeping registers; reset empties both banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_full_q <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      fill_full_q <= fill_full_d;
      rd_sel_q    <= rd_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sa_tile_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank (
      .clk        (clk),
      .we_i       (accept && (rd_sel_q != 1'(b))),
      .wr_k_i     (k_q),
      .wr_a_col_i (in_a_col),
      .wr_b_row_i (in_b_row),
      .rd_idx_i   (rd_idx),
      .rd_a_o     (rd_a_bank[b]),
      .rd_b_o     (rd_b_bank[b])
    );
  end

  assign rd_a = rd_a_bank[rd_sel_d];
  assign rd_b = rd_b_bank[rd_sel_d];
`else
  assign in_ready = (state_q == LOAD);
  assign full_now = last_beat;

  sa_tile_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank (
    .clk        (clk),
    .we_i       (accept),
    .wr_k_i     (k_q),
    .wr_a_col_i (in_a_col),
    .wr_b_row_i (in_b_row),
    .rd_idx_i   (rd_idx),
    .rd_a_o     (rd_a),
    .rd_b_o     (rd_b)
  );
`endif

  // Next-state logic: beat counter in LOAD, tile timeline counter t from STREAM through DONE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    if (accept) k_d = last_beat ? '0 : k_q + 1'b1;
    case (state_q)
      LOAD:   if (full_now) state_d = CLEAR;
      CLEAR: begin
        state_d = STREAM;
        t_d     = '0;
      end
      STREAM: begin
        t_d = t_q + 1'b1;
        if (t_q == CW'(2 * N - 2)) state_d = (DONE_T == 2 * N - 1) ? DONE : DRAIN;
      end
      DRAIN: begin
        t_d = t_q + 1'b1;
        if (t_q == CW'(DONE_T - 1)) state_d = DONE;
      end
      DONE:   state_d = full_now ? CLEAR : LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Skew: lane g shows element t-g while 0 <= t-g < N, computed for the upcoming cycle.
  for (genvar g = 0; g < N; g++) begin : g_skew
    logic [CW:0] diff;
    logic        vld;
    assign diff = {1'b0, t_d} - (CW+1)'(g);
    assign vld  = (state_d == STREAM) && ({1'b0, t_d} >= (CW+1)'(g)) && (diff < (CW+1)'(N));
    assign rd_idx[g*IW +: IW] = diff[IW-1:0];
    assign arr_a_d[g*DATA_WIDTH +: DATA_WIDTH] = vld ? rd_a[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign arr_b_d[g*DATA_WIDTH +: DATA_WIDTH] = vld ? rd_b[g*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // State, counters and registered edge operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      k_q     <= '0;
      t_q     <= '0;
      arr_a_q <= '0;
      arr_b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      arr_a_q <= arr_a_d;
      arr_b_q <= arr_b_d;
    end
  end

  assign arr_clr   = (state_q == CLEAR);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != LOAD);
  assign arr_a     = arr_a_q;
  assign arr_b     = arr_b_q;

endmodule

// File: tb/tb_sa_tile_feeder.sv
// tb/tb_sa_tile_feeder.sv - directed self-checking bench for sa_tile_feeder
module tb_sa_tile_feeder;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int PE_LAT = 1;
  localparam int DONE_T = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_a_col = '0;
  logic [N*DW-1:0] in_b_row = '0;
  logic            arr_clr;
  logic [N*DW-1:0] arr_a;
  logic [N*DW-1:0] arr_b;
  logic            res_valid;
  logic            busy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] A [N][N];
  logic [DW-1:0] B [N][N];

  sa_tile_feeder #(.N(N), .DATA_WIDTH(DW), .PE_LAT(PE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a_col  (in_a_col),
    .in_b_row  (in_b_row),
    .arr_clr   (arr_clr),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N*DW-1:0] col(input int k);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = A[i][k];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] row(input int k);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = B[k][j];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_a(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (t - i >= 0 && t - i < N) r[i*DW +: DW] = A[i][t-i];
    return r;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t);
    logic [N*DW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) if (t - j >= 0 && t - j < N) r[j*DW +: DW] = B[t-j][j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_tile();
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_a_col = col(k);
      in_b_row = row(k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_tile();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 30) begin
      failures++;
      $display("FAIL finish_timeout busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (arr_clr !== 1'b0) begin failures++; $display("FAIL reset_arr_clr got=%0b exp=0", arr_clr); end
    checks++; if (arr_a !== '0) begin failures++; $display("FAIL reset_arr_a got=%h exp=0", arr_a); end
    checks++; if (arr_b !== '0) begin failures++; $display("FAIL reset_arr_b got=%h exp=0", arr_b); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_beat_count();
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = (i == j) ? 8'd1 : 8'd0;
        B[i][j] = 8'(j + 1);
      end
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_a_col = col(k);
      in_b_row = row(k);
      tick();
      if (k < N - 1) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL beat_in_ready k=%0d got=%0b exp=1", k, in_ready); end
      end
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL beat_ready_after_last got=%0b exp=0", in_ready); end
    checks++; if (arr_clr !== 1'b1) begin failures++; $display("FAIL beat_clear got=%0b exp=1", arr_clr); end
    for (int t = 0; t <= DONE_T + 1; t++) begin
      tick();
      checks++; if (arr_clr !== 1'b0) begin failures++; $display("FAIL beat_clr_once t=%0d got=%0b exp=0", t, arr_clr); end
      checks++; if (res_valid !== 1'(t == DONE_T)) begin failures++; $display("FAIL beat_res_valid t=%0d got=%0b exp=%0b", t, res_valid, t == DONE_T); end
      checks++; if (busy !== 1'(t <= DONE_T)) begin failures++; $display("FAIL beat_busy t=%0d got=%0b exp=%0b", t, busy, t <= DONE_T); end
      checks++; if (arr_a !== exp_a(t)) begin failures++; $display("FAIL beat_arr_a t=%0d got=%h exp=%h", t, arr_a, exp_a(t)); end
      checks++; if (arr_b !== exp_b(t)) begin failures++; $display("FAIL beat_arr_b t=%0d got=%h exp=%h", t, arr_b, exp_b(t)); end
    end
  endtask

  task automatic test_skew();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = 8'(16 * i + k);
        B[i][k] = 8'(8'h80 + 16 * i + k);
      end
    load_tile();
    for (int t = 0; t <= 6; t++) begin
      tick();
      if (t == 0) begin
        checks++; if (arr_a !== 32'h0000_0000) begin failures++; $display("FAIL skew_a_t0 got=%h exp=00000000", arr_a); end
        checks++; if (arr_b !== 32'h0000_0080) begin failures++; $display("FAIL skew_b_t0 got=%h exp=00000080", arr_b); end
      end
      if (t == 3) begin
        checks++; if (arr_a !== 32'h3021_1203) begin failures++; $display("FAIL skew_a_t3 got=%h exp=30211203", arr_a); end
        checks++; if (arr_b !== 32'h8392_A1B0) begin failures++; $display("FAIL skew_b_t3 got=%h exp=8392a1b0", arr_b); end
      end
      if (t == 6) begin
        checks++; if (arr_a !== 32'h3300_0000) begin failures++; $display("FAIL skew_a_t6 got=%h exp=33000000", arr_a); end
      end
    end
    finish_tile();
  endtask

  task automatic test_gapped();
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int nacc;
    nacc = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) A[i][k] = 8'(16 * i + k + 1);
    for (int c = 0; c < 7; c++) begin
      if (pat[c] == 1) begin
        in_valid = 1'b1;
        in_a_col = col(nacc);
        in_b_row = row(nacc);
      end else begin
        in_valid = 1'b0;
        in_a_col = '1;
        in_b_row = '1;
      end
      tick();
      if (pat[c] == 1) nacc++;
      checks++; if (arr_clr !== 1'(nacc == N)) begin failures++; $display("FAIL gap_clr c=%0d got=%0b exp=%0b", c, arr_clr, nacc == N); end
      checks++; if (in_ready !== 1'(nacc < N)) begin failures++; $display("FAIL gap_ready c=%0d got=%0b exp=%0b", c, in_ready, nacc < N); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (arr_a !== 32'h0000_0001) begin failures++; $display("FAIL gap_a_t0 got=%h exp=00000001", arr_a); end
    repeat (3) tick();
    checks++; if (arr_a !== 32'h3122_1304) begin failures++; $display("FAIL gap_a_t3 got=%h exp=31221304", arr_a); end
    finish_tile();
  endtask

  task automatic test_ignored();
    load_tile();
    in_valid = 1'b1;
    in_a_col = '1;
    in_b_row = '1;
    for (int t = 0; t <= DONE_T; t++) begin
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_ready t=%0d got=%0b exp=0", t, in_ready); end
      if (t == 3) begin
        checks++; if (arr_a !== 32'h3122_1304) begin failures++; $display("FAIL ign_a_t3 got=%h exp=31221304", arr_a); end
      end
    end
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ign_ready_back got=%0b exp=1", in_ready); end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        A[i][k] = 8'(8'h40 + 4 * i + k);
        B[i][k] = 8'(8'hC0 + 4 * i + k);
      end
    load_tile();
    tick();
    checks++; if (arr_a !== 32'h0000_0040) begin failures++; $display("FAIL ign_next_a_t0 got=%h exp=00000040", arr_a); end
    checks++; if (arr_b !== 32'h0000_00C0) begin failures++; $display("FAIL ign_next_b_t0 got=%h exp=000000c0", arr_b); end
    finish_tile();
  endtask

  task automatic test_mid_reset();
    int pulses;
    int pos;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) A[i][k] = 8'(16 * i + k);
    load_tile();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (arr_a !== '0) begin failures++; $display("FAIL mrst_arr_a got=%h exp=0", arr_a); end
    checks++; if (arr_b !== '0) begin failures++; $display("FAIL mrst_arr_b got=%h exp=0", arr_b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mrst_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_ready got=%0b exp=1", in_ready); end
    pulses = 0;
    repeat (15) begin
      tick();
      if (res_valid === 1'b1 || arr_clr === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mrst_stray_pulses got=%0d exp=0", pulses); end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) A[i][k] = 8'(16 * i + k + 1);
    load_tile();
    pos = -1;
    for (int t = 0; t <= DONE_T + 2; t++) begin
      tick();
      if (t == 3) begin
        checks++; if (arr_a !== 32'h3122_1304) begin failures++; $display("FAIL mrst_fresh_a_t3 got=%h exp=31221304", arr_a); end
      end
      if (res_valid === 1'b1 && pos < 0) pos = t;
    end
    checks++; if (pos != DONE_T) begin failures++; $display("FAIL mrst_fresh_done got=%0d exp=%0d", pos, DONE_T); end
  endtask

`ifdef SA_FEEDER_DOUBLE_BUF_EN
  task automatic test_overlap();
    int p1, p2, clr2, c;
    p1 = -1; p2 = -1; clr2 = -1; c = 0;
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) A[i][k] = 8'(16 * i + k);
    load_tile();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) A[i][k] = 8'(16 * i + k + 1);
    for (int k = 0; k < N; k++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ovl_ready k=%0d got=%0b exp=1", k, in_ready); end
      in_valid = 1'b1;
      in_a_col = col(k);
      in_b_row = row(k);
      tick();
      c++;
    end
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovl_full got=%0b exp=0", in_ready); end
    while (c < 40 && p2 < 0) begin
      tick();
      c++;
      if (res_valid === 1'b1) begin
        if (p1 < 0) p1 = c; else p2 = c;
      end
      if (arr_clr === 1'b1 && p1 >= 0 && clr2 < 0) clr2 = c;
    end
    checks++; if (clr2 != p1 + 1) begin failures++; $display("FAIL ovl_clr got=%0d exp=%0d", clr2, p1 + 1); end
    checks++; if (p2 - p1 != DONE_T + 2) begin failures++; $display("FAIL ovl_period got=%0d exp=%0d", p2 - p1, DONE_T + 2); end
  endtask
`endif

  initial begin
    test_reset();
    test_beat_count();
    test_skew();
    test_gapped();
`ifndef SA_FEEDER_DOUBLE_BUF_EN
    test_ignored();
`endif
    test_mid_reset();
`ifdef SA_FEEDER_DOUBLE_BUF_EN
    test_overlap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
